// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back front end.
package wb_pkg;

   localparam int XLEN      = 32;
   localparam int REG_IDX_W = 5;

   localparam logic [REG_IDX_W-1:0] X0_IDX = '0;

   typedef struct packed {
      logic [REG_IDX_W-1:0] idx;
      logic [XLEN-1:0]      data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Ordered ring buffer of multi-cycle results {idx, data}; DEPTH must be a power of two.
module wb_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  wb_pkg::wb_entry_t      push_entry,
   input  logic                   pop,
   output wb_pkg::wb_entry_t      head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   import wb_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // No push-through: a full FIFO refuses pushes even when popping.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_entry;
   end

endmodule

// File: rtl/reg_writeback.sv
// Merges ALU and buffered multi-cycle results onto the register-file write port and
// tracks pending destinations. Define WB_BYPASS_EN to let an idle path skip the FIFO.
module reg_writeback #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         alu_valid,
   input  logic [wb_pkg::REG_IDX_W-1:0] alu_idx,
   input  logic [XLEN-1:0]              alu_data,
   input  logic                         mc_valid,
   output logic                         mc_ready,
   input  logic [wb_pkg::REG_IDX_W-1:0] mc_idx,
   input  logic [XLEN-1:0]              mc_data,
   input  logic                         iss_valid,
   input  logic [wb_pkg::REG_IDX_W-1:0] iss_idx,
   input  logic [wb_pkg::REG_IDX_W-1:0] chk_idx1,
   input  logic [wb_pkg::REG_IDX_W-1:0] chk_idx2,
   output logic                         busy1,
   output logic                         busy2,
   output logic                         wr_en,
   output logic [wb_pkg::REG_IDX_W-1:0] wr_idx,
   output logic [XLEN-1:0]              wr_data,
   output logic [$clog2(DEPTH):0]       fifo_count
);
   import wb_pkg::*;

   logic [31:0] sb;
   logic [31:0] set_mask;
   logic [31:0] clr_mask;
   wb_entry_t   head;
   wb_entry_t   push_entry;
   logic        full;
   logic        empty;
   logic        alu_wr;
   logic        mc_fire;
   logic        byp;
   logic        push;
   logic        pop;

   // Multi-cycle handshake: a result transfers at a rising edge where mc_valid && mc_ready;
   // mc_valid is never gated by mc_ready and mc_ready is low throughout reset.
   assign mc_ready = rst && !full;
   assign mc_fire  = mc_valid && mc_ready;
   assign alu_wr   = alu_valid && (alu_idx != X0_IDX);

`ifdef WB_BYPASS_EN
   assign byp = mc_fire && empty && !alu_wr;
`else
   assign byp = 1'b0;
`endif

   assign push       = mc_fire && !byp;
   assign pop        = !alu_wr && !empty;
   assign push_entry = '{idx: mc_idx, data: mc_data};

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .count      (fifo_count),
      .full       (full),
      .empty      (empty)
   );

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (pop)      clr_mask[head.idx] = 1'b1;
      else if (byp) clr_mask[mc_idx]   = 1'b1;
      if (iss_valid) set_mask[iss_idx] = 1'b1;
   end

   // Set is applied after clear so a same-cycle reissue keeps the register pending.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sb <= '0;
      else      sb <= ((sb & ~clr_mask) | set_mask) & ~32'd1;
   end

   assign busy1 = sb[chk_idx1];
   assign busy2 = sb[chk_idx2];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_en   <= 1'b0;
         wr_idx  <= '0;
         wr_data <= '0;
      end else if (alu_wr) begin
         wr_en   <= 1'b1;
         wr_idx  <= alu_idx;
         wr_data <= alu_data;
      end else if (pop) begin
         // An x0 entry is consumed silently; the write port keeps its last idx/data.
         wr_en <= (head.idx != X0_IDX);
         if (head.idx != X0_IDX) begin
            wr_idx  <= head.idx;
            wr_data <= head.data;
         end
      end else if (byp) begin
         wr_en <= (mc_idx != X0_IDX);
         if (mc_idx != X0_IDX) begin
            wr_idx  <= mc_idx;
            wr_data <= mc_data;
         end
      end else begin
         wr_en <= 1'b0;
      end
   end

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: vector table, directed corner sequences, random traffic.
module tb_reg_writeback;

   localparam int DEPTH = 4;
   localparam int XLEN  = 32;

   logic              clk;
   logic              rst;
   logic              alu_valid;
   logic [4:0]        alu_idx;
   logic [XLEN-1:0]   alu_data;
   logic              mc_valid;
   logic              mc_ready;
   logic [4:0]        mc_idx;
   logic [XLEN-1:0]   mc_data;
   logic              iss_valid;
   logic [4:0]        iss_idx;
   logic [4:0]        chk_idx1;
   logic [4:0]        chk_idx2;
   logic              busy1;
   logic              busy2;
   logic              wr_en;
   logic [4:0]        wr_idx;
   logic [XLEN-1:0]   wr_data;
   logic [2:0]        fifo_count;

   reg_writeback #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk        (clk),
      .rst        (rst),
      .alu_valid  (alu_valid),
      .alu_idx    (alu_idx),
      .alu_data   (alu_data),
      .mc_valid   (mc_valid),
      .mc_ready   (mc_ready),
      .mc_idx     (mc_idx),
      .mc_data    (mc_data),
      .iss_valid  (iss_valid),
      .iss_idx    (iss_idx),
      .chk_idx1   (chk_idx1),
      .chk_idx2   (chk_idx2),
      .busy1      (busy1),
      .busy2      (busy2),
      .wr_en      (wr_en),
      .wr_idx     (wr_idx),
      .wr_data    (wr_data),
      .fifo_count (fifo_count)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // scoreboard: expected writes in commit order, plus a reference model of FIFO and pending bits
   logic [36:0] exp_q[$];
   logic [36:0] mq[$];
   logic [31:0] sb_m;
   logic        exp_wen;
   logic [4:0]  last_idx;
   logic [31:0] last_data;

   typedef struct {
      logic        av;
      logic [4:0]  ai;
      logic [31:0] ad;
      logic        mv;
      logic [4:0]  mi;
      logic [31:0] md;
      logic        wen;
      logic [4:0]  widx;
      logic [31:0] wdata;
      int          cnt;
      logic        rdy;
   } vec_t;

   vec_t vt[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      exp_q.delete();
      sb_m      = '0;
      exp_wen   = 1'b0;
      last_idx  = '0;
      last_data = '0;
   endtask

   // driver: called at posedge+1, applies inputs for the next edge and checks after it
   task automatic step(input logic av, input logic [4:0] ai, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mi, input logic [31:0] md,
                       input logic iv, input logic [4:0] ii);
      logic        ready;
      logic        fire;
      logic        aw;
      logic        byp;
      logic [36:0] e;
      alu_valid = av; alu_idx = ai; alu_data = ad;
      mc_valid  = mv; mc_idx  = mi; mc_data  = md;
      iss_valid = iv; iss_idx = ii;
      #1;
      ready = (mq.size() < DEPTH);
      check("mc_ready", 32'(mc_ready), 32'(ready));
      fire = mv && ready;
      aw   = av && (ai != 5'd0);
      byp  = 1'b0;
`ifdef WB_BYPASS_EN
      byp = fire && (mq.size() == 0) && !aw;
`endif
      exp_wen = 1'b0;
      if (aw) begin
         exp_wen = 1'b1;
         exp_q.push_back({ai, ad});
         last_idx = ai; last_data = ad;
      end else if (mq.size() > 0) begin
         e = mq.pop_front();
         sb_m[e[36:32]] = 1'b0;
         if (e[36:32] != 5'd0) begin
            exp_wen = 1'b1;
            exp_q.push_back(e);
            last_idx = e[36:32]; last_data = e[31:0];
         end
      end else if (byp) begin
         sb_m[mi] = 1'b0;
         if (mi != 5'd0) begin
            exp_wen = 1'b1;
            exp_q.push_back({mi, md});
            last_idx = mi; last_data = md;
         end
      end
      if (fire && !byp) mq.push_back({mi, md});
      if (iv) sb_m[ii] = 1'b1;
      sb_m[0] = 1'b0;
      @(posedge clk);
      #1;
      check("wr_en", 32'(wr_en), 32'(exp_wen));
      if (wr_en) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write actual=%0d:0x%0h expected=none", wr_idx, wr_data);
         end else begin
            e = exp_q.pop_front();
            if ({wr_idx, wr_data} !== e) begin
               failures++;
               $display("FAIL write_order actual=%0d:0x%0h expected=%0d:0x%0h",
                        wr_idx, wr_data, e[36:32], e[31:0]);
            end
         end
      end
      check("wr_idx", 32'(wr_idx), 32'(last_idx));
      check("wr_data", wr_data, last_data);
      check("fifo_count", 32'(fifo_count), 32'(mq.size()));
      check("busy1", 32'(busy1), 32'(sb_m[chk_idx1]));
      check("busy2", 32'(busy2), 32'(sb_m[chk_idx2]));
   endtask

   task automatic idle();
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
   endtask

   initial begin
      logic bypass_on;
      bypass_on = 1'b0;
`ifdef WB_BYPASS_EN
      bypass_on = 1'b1;
`endif
      vt[0]  = '{1'b1, 5'd1, 32'hA000_0001, 1'b1, 5'd10, 32'h100, 1'b1, 5'd1,  32'hA000_0001, 1, 1'b1};
      vt[1]  = '{1'b1, 5'd2, 32'hA000_0002, 1'b1, 5'd11, 32'h101, 1'b1, 5'd2,  32'hA000_0002, 2, 1'b1};
      vt[2]  = '{1'b1, 5'd3, 32'hA000_0003, 1'b1, 5'd12, 32'h102, 1'b1, 5'd3,  32'hA000_0003, 3, 1'b1};
      vt[3]  = '{1'b1, 5'd4, 32'hA000_0004, 1'b1, 5'd13, 32'h103, 1'b1, 5'd4,  32'hA000_0004, 4, 1'b0};
      vt[4]  = '{1'b1, 5'd5, 32'hA000_0005, 1'b1, 5'd14, 32'h104, 1'b1, 5'd5,  32'hA000_0005, 4, 1'b0};
      vt[5]  = '{1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0,  32'h0,   1'b1, 5'd10, 32'h100,       3, 1'b1};
      vt[6]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd14, 32'h104, 1'b1, 5'd11, 32'h101,       3, 1'b1};
      vt[7]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd0,  32'h55,  1'b1, 5'd12, 32'h102,       3, 1'b1};
      vt[8]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,   1'b1, 5'd13, 32'h103,       2, 1'b1};
      vt[9]  = '{1'b1, 5'd0, 32'h0BAD,      1'b0, 5'd0,  32'h0,   1'b1, 5'd14, 32'h104,       1, 1'b1};
      vt[10] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,   1'b0, 5'd14, 32'h104,       0, 1'b1};
      vt[11] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,   1'b0, 5'd14, 32'h104,       0, 1'b1};

      rst = 1'b0;
      alu_valid = 0; alu_idx = 0; alu_data = 0;
      mc_valid = 0; mc_idx = 0; mc_data = 0;
      iss_valid = 0; iss_idx = 0;
      chk_idx1 = 5'd0; chk_idx2 = 5'd5;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_wr_idx", 32'(wr_idx), 32'd0);
      check("rst_wr_data", wr_data, 32'd0);
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_mc_ready", 32'(mc_ready), 32'd0);
      check("rst_busy2", 32'(busy2), 32'd0);
      rst = 1'b1;

      // single ALU write, visible for exactly one cycle
      step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      check("alu_wen", 32'(wr_en), 32'd1);
      check("alu_idx", 32'(wr_idx), 32'd5);
      check("alu_data", wr_data, 32'hDEAD_BEEF);
      idle();
      check("alu_wen_drop", 32'(wr_en), 32'd0);

      // issue idx 7, then return its result
      chk_idx1 = 5'd7;
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
      check("iss_busy", 32'(busy1), 32'd1);
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12, 1'b0, 5'd0);
      check("mc_accept_wen", 32'(wr_en), 32'(bypass_on));
      check("mc_accept_busy", 32'(busy1), 32'(!bypass_on));
      idle();
      check("mc_next_wen", 32'(wr_en), 32'(!bypass_on));
      check("mc_idx", 32'(wr_idx), 32'd7);
      check("mc_data", wr_data, 32'h12);
      check("mc_busy_clear", 32'(busy1), 32'd0);

      // table: ALU starves a filling FIFO, then drain with x0 entries
      for (int i = 0; i < 12; i++) begin
         step(vt[i].av, vt[i].ai, vt[i].ad, vt[i].mv, vt[i].mi, vt[i].md, 1'b0, 5'd0);
         check($sformatf("vec%0d_wen", i), 32'(wr_en), 32'(vt[i].wen));
         check($sformatf("vec%0d_idx", i), 32'(wr_idx), 32'(vt[i].widx));
         check($sformatf("vec%0d_data", i), wr_data, vt[i].wdata);
         check($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vt[i].cnt));
         check($sformatf("vec%0d_ready", i), 32'(mc_ready), 32'(vt[i].rdy));
      end

      // reissue of idx 3 on the edge that pops its result keeps it pending
      chk_idx1 = 5'd3;
      step(1'b1, 5'd9, 32'h99, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
      check("reissue_wen", 32'(wr_en), 32'd1);
      check("reissue_idx", 32'(wr_idx), 32'd3);
      check("reissue_busy", 32'(busy1), 32'd1);

      // asynchronous reset with buffered entries and pending bits
      chk_idx1 = 5'd26; chk_idx2 = 5'd27;
      step(1'b1, 5'd20, 32'h20, 1'b1, 5'd23, 32'h23, 1'b1, 5'd26);
      step(1'b1, 5'd21, 32'h21, 1'b1, 5'd24, 32'h24, 1'b1, 5'd27);
      step(1'b1, 5'd22, 32'h22, 1'b1, 5'd25, 32'h25, 1'b0, 5'd0);
      check("pre_rst_count", 32'(fifo_count), 32'd3);
      check("pre_rst_busy", 32'({busy1, busy2}), 32'd3);
      alu_valid = 0; mc_valid = 0; iss_valid = 0;
      #2;
      rst = 1'b0;
      #1;
      check("arst_count", 32'(fifo_count), 32'd0);
      check("arst_wen", 32'(wr_en), 32'd0);
      check("arst_idx", 32'(wr_idx), 32'd0);
      check("arst_data", wr_data, 32'd0);
      check("arst_busy1", 32'(busy1), 32'd0);
      check("arst_busy2", 32'(busy2), 32'd0);
      check("arst_ready", 32'(mc_ready), 32'd0);
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (6) idle();

      // random traffic against the reference model
      for (int n = 0; n < 300; n++) begin
         chk_idx1 = 5'($urandom_range(0, 31));
         chk_idx2 = 5'($urandom_range(0, 31));
         step($urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)), $urandom,
              $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
              $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)));
      end
      repeat (DEPTH + 2) idle();
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
